filter_scheduler: RTL and testbench

//   Time-shares one two-tap filter datapath (inputs x_n, x_n_1; output y) between NCH sample sources.
//   - Grants sources round-robin and keeps each channel's previous sample (x_n_1 history).
//   - Issues one computation at a time and returns the result tagged with its channel.
//   - Sits between the per-channel sample producers and the shared sequence datapath.

---
 rtl/filter_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_filter_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_scheduler.sv
// filter_scheduler: round-robin time-sharing of one two-tap filter datapath
// between NCH sample sources. It keeps the previous sample of each channel,
// runs one datapath transaction at a time, and returns each result tagged
// with the channel it came from.
module filter_scheduler #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*W-1:0]         in_data,
    output logic [NCH-1:0]           in_ready,
    output logic                     dp_start,
    output logic [W-1:0]             dp_x_n,
    output logic [W-1:0]             dp_x_n_1,
    input  logic [W-1:0]             dp_y,
    input  logic                     dp_done,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NCH)-1:0]   out_ch,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [W-1:0]  cur_x_q,    cur_x_d;
    logic [W-1:0]  cur_x1_q,   cur_x1_d;
    logic [CW-1:0] cur_ch_q,   cur_ch_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q,   out_ch_d;
    logic          err_q,      err_d;
    logic [W-1:0]  hist_q [NCH];

    logic          grant_found;
    logic [CW-1:0] grant_ch;
    logic [W-1:0]  grant_x;
    logic [W-1:0]  grant_hist;
    logic          hist_we;

    // Channel index (base + off) modulo NCH; works for non-power-of-two NCH.
    function automatic logic [CW-1:0] ch_add(input logic [CW-1:0] base,
                                             input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return CW'(sum % NCH);
    endfunction

    // Round-robin search: first requesting channel at or after rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!grant_found && in_valid[ch_add(rr_ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_ch    = ch_add(rr_ptr_q, i);
            end
        end
    end

    // Select the granted channel's new sample and its stored history.
    always_comb begin
        grant_x    = '0;
        grant_hist = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_ch == CW'(i)) begin
                grant_x    = in_data[i*W +: W];
                grant_hist = hist_q[i];
            end
        end
    end

    // Transaction sequencing: accept, issue, wait for the datapath, deliver.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_x_d    = cur_x_q;
        cur_x1_d   = cur_x1_q;
        cur_ch_d   = cur_ch_q;
        timer_d    = timer_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        err_d      = err_q;
        hist_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    cur_x_d  = grant_x;
                    cur_x1_d = grant_hist;
                    cur_ch_d = grant_ch;
                    hist_we  = 1'b1;
                    rr_ptr_d = ch_add(grant_ch, 1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    out_data_d = dp_y;
                    out_ch_d   = cur_ch_q;
                    state_d    = S_OUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // Abort as the count reaches TIMEOUT-1, so the scheduler
                    // is back in IDLE exactly TIMEOUT cycles after dp_start.
                    if (timer_q == TW'(TIMEOUT - 2)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cur_x_q    <= '0;
            cur_x1_q   <= '0;
            cur_ch_q   <= '0;
            timer_q    <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_x_q    <= cur_x_d;
            cur_x1_q   <= cur_x1_d;
            cur_ch_q   <= cur_ch_d;
            timer_q    <= timer_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            err_q      <= err_d;
            if (hist_we) begin
                hist_q[grant_ch] <= grant_x;
            end
        end
    end

    // Accept pulse only to the granted channel, only while idle.
    always_comb begin
        in_ready = '0;
        if (state_q == S_IDLE && grant_found && !reset) begin
            in_ready[grant_ch] = 1'b1;
        end
    end

    assign dp_start    = (state_q == S_ISSUE);
    assign dp_x_n      = cur_x_q;
    assign dp_x_n_1    = cur_x1_q;
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_filter_scheduler.sv
// Self-checking bench for filter_scheduler: table-driven single samples,
// hand-written corner sequences, then randomized traffic against a
// transaction-level reference model.
module tb_filter_scheduler;

    localparam int NCH     = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*W-1:0]  in_data = '0;
    logic [NCH-1:0]    in_ready;
    logic              dp_start;
    logic [W-1:0]      dp_x_n;
    logic [W-1:0]      dp_x_n_1;
    logic [W-1:0]      dp_y;
    logic              dp_done;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [0:0]        out_ch;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Datapath model controls
    int dp_delay = 2;
    bit dp_hang  = 1'b0;
    bit dp_force = 1'b0;

    filter_scheduler #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dp_start(dp_start), .dp_x_n(dp_x_n),
        .dp_x_n_1(dp_x_n_1), .dp_y(dp_y), .dp_done(dp_done),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: y = x_n + x_n_1 mod 2^W, done dp_delay cycles after start.
    int          dp_cnt = 0;
    logic [W-1:0] dp_sum = '0;
    initial begin
        dp_done = 1'b0;
        dp_y    = '0;
        forever begin
            @(negedge clk);
            dp_done = dp_force;
            dp_y    = $urandom;
            if (reset) begin
                dp_cnt = 0;
            end else begin
                if (dp_cnt > 0) begin
                    dp_cnt = dp_cnt - 1;
                    if (dp_cnt == 0 && !dp_hang) begin
                        dp_done = 1'b1;
                        dp_y    = dp_sum;
                    end
                end
                if (dp_start) begin
                    dp_cnt = dp_delay;
                    dp_sum = dp_x_n + dp_x_n_1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        #1;
        chk({nm, "_in_ready"}, 32'(in_ready), 0);
        chk({nm, "_dp_start"}, 32'(dp_start), 0);
        chk({nm, "_dp_x_n"}, dp_x_n, 0);
        chk({nm, "_dp_x_n_1"}, dp_x_n_1, 0);
        chk({nm, "_out_valid"}, 32'(out_valid), 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_out_ch"}, 32'(out_ch), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_err"}, 32'(err_timeout), 0);
    endtask

    // Called with inputs already settled; returns the grant cycle.
    task automatic grant_wait(input int ch, input string nm, output int t0);
        int n = 0;
        while (in_ready === '0 && n < 30) begin
            step();
            #1;
            n++;
        end
        chk({nm, "_grant"}, 32'(in_ready), 32'(1) << ch);
        t0 = cyc;
    endtask

    task automatic wait_out(input logic [31:0] ey, input int ech, input int t0,
                            input int elat, input string nm);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            #1;
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_latency"}, cyc - t0, elat);
        chk({nm, "_data"}, out_data, ey);
        chk({nm, "_ch"}, 32'(out_ch), ech);
    endtask

    task automatic send(input int ch, input logic [31:0] x, input logic [31:0] ey,
                        input string nm);
        int t0;
        in_valid = NCH'(1) << ch;
        in_data[ch*W +: W] = x;
        out_ready = 1'b1;
        #1;
        grant_wait(ch, nm, t0);
        step();
        in_valid = '0;
        #1;
        wait_out(ey, ch, t0, 2 + dp_delay, nm);
        step();
    endtask

    typedef struct {
        bit          rst_before;
        int          ch;
        logic [31:0] x;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs [7];

    // Reference model state for the randomized phase
    logic [W-1:0] m_hist [NCH];
    int           m_ptr;
    bit           m_busy;
    int           m_k;
    int           m_ch;
    logic [W-1:0] m_x, m_x1, m_y;

    initial begin
        int t0;
        int g;
        int ng, no, idx0, idx1;
        logic [31:0] s0 [2];
        logic [31:0] s1 [2];
        int g_exp [4];
        logic [31:0] y_exp [4];

        vecs[0] = '{1'b1, 0, 32'd5,         32'd5};
        vecs[1] = '{1'b0, 0, 32'd7,         32'd12};
        vecs[2] = '{1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 0, 32'd1,         32'h0000_0000};
        vecs[4] = '{1'b0, 1, 32'd9,         32'd9};
        vecs[5] = '{1'b0, 1, 32'd4,         32'd13};
        vecs[6] = '{1'b0, 0, 32'd3,         32'd4};

        step();
        do_reset();
        chk_reset_outputs("reset");
        step();

        // Table: one done cycle after dp_start gives the minimum 3-cycle latency
        dp_delay = 1;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst_before) begin
                do_reset();
            end
            send(vecs[i].ch, vecs[i].x, vecs[i].exp_y, $sformatf("vec%0d", i));
        end

        // Two channels streaming together: strict alternation
        dp_delay = 2;
        do_reset();
        s0 = '{32'd1, 32'd2};
        s1 = '{32'd10, 32'd20};
        g_exp = '{0, 1, 0, 1};
        y_exp = '{32'd1, 32'd10, 32'd3, 32'd30};
        ng = 0; no = 0; idx0 = 0; idx1 = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && no < 4; c++) begin
            in_valid = {idx1 < 2, idx0 < 2};
            in_data  = {(idx1 < 2) ? s1[idx1] : 32'd0, (idx0 < 2) ? s0[idx0] : 32'd0};
            #1;
            if (in_ready !== '0 && ng < 4) begin
                chk("rr_grant", 32'(in_ready), 32'(1) << g_exp[ng]);
                if (in_ready[0]) idx0++;
                if (in_ready[1]) idx1++;
                ng++;
            end
            if (out_valid === 1'b1) begin
                chk("rr_data", out_data, y_exp[no]);
                chk("rr_ch", 32'(out_ch), g_exp[no]);
                no++;
            end
            step();
        end
        chk("rr_out_count", no, 4);
        in_valid = '0;

        // Backpressure in OUT
        do_reset();
        in_valid = 2'b01;
        in_data[0 +: W] = 32'd11;
        #1;
        grant_wait(0, "bp", t0);
        step();
        in_valid = 2'b10;
        in_data[W +: W] = 32'd50;
        #1;
        wait_out(32'd11, 0, t0, 4, "bp");
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", out_data, 32'd11);
            chk("bp_hold_ch", 32'(out_ch), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        step();
        #1;
        chk("bp_next_grant", 32'(in_ready), 32'b10);
        t0 = cyc;
        step();
        in_valid = '0;
        #1;
        wait_out(32'd50, 1, t0, 4, "bp2");
        step();

        // Stray dp_done while idle is ignored, then a datapath timeout
        do_reset();
        dp_force = 1'b1;
        step();
        step();
        #1;
        chk("stray_done_busy", 32'(busy), 0);
        chk("stray_done_valid", 32'(out_valid), 0);
        dp_force = 1'b0;
        step();
        dp_hang = 1'b1;
        in_valid = 2'b01;
        in_data[0 +: W] = 32'd6;
        #1;
        grant_wait(0, "to", t0);
        step();
        in_valid = '0;
        #1;
        chk("to_dp_start", 32'(dp_start), 1);
        chk("to_x_n", dp_x_n, 32'd6);
        chk("to_x_n_1", dp_x_n_1, 32'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            #1;
            chk($sformatf("to_out_valid_k%0d", k), 32'(out_valid), 0);
            chk($sformatf("to_err_k%0d", k), 32'(err_timeout), (k == TIMEOUT) ? 1 : 0);
            chk($sformatf("to_busy_k%0d", k), 32'(busy), (k == TIMEOUT) ? 0 : 1);
        end
        dp_hang = 1'b0;
        step();
        send(0, 32'd2, 32'd8, "after_to");
        #1;
        chk("to_err_sticky", 32'(err_timeout), 1);
        step();

        // Reset during WAIT clears history and everything in flight
        do_reset();
        send(1, 32'd4, 32'd4, "rw_prime");
        in_valid = 2'b10;
        in_data[W +: W] = 32'd9;
        #1;
        grant_wait(1, "rw", t0);
        step();
        in_valid = '0;
        #1;
        chk("rw_x_n", dp_x_n, 32'd9);
        chk("rw_x_n_1", dp_x_n_1, 32'd4);
        step();
        #1;
        chk("rw_in_wait", 32'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_outputs("rw_reset");
        step();
        send(1, 32'd3, 32'd3, "rw_after");

        // Randomized traffic against the reference model
        dp_delay = 2;
        do_reset();
        m_ptr = 0;
        m_busy = 1'b0;
        m_k = 0;
        for (int i = 0; i < NCH; i++) m_hist[i] = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = NCH'($urandom);
            in_data   = {$urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_busy) begin
                for (int i = 0; i < NCH; i++) begin
                    if (g < 0 && in_valid[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
                end
            end
            chk("rnd_in_ready", 32'(in_ready), (g >= 0) ? (32'(1) << g) : 32'd0);
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_dp_start", 32'(dp_start), (m_busy && m_k == 1) ? 1 : 0);
            chk("rnd_out_valid", 32'(out_valid), (m_busy && m_k >= 4) ? 1 : 0);
            if (m_busy && m_k >= 4) begin
                chk("rnd_out_data", out_data, m_y);
                chk("rnd_out_ch", 32'(out_ch), m_ch);
            end
            if (m_busy && m_k <= 3) begin
                chk("rnd_x_n", dp_x_n, m_x);
                chk("rnd_x_n_1", dp_x_n_1, m_x1);
            end
            chk("rnd_err", 32'(err_timeout), 0);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_ch   = g;
                m_x    = in_data[g*W +: W];
                m_x1   = m_hist[g];
                m_y    = m_x + m_x1;
                m_hist[g] = m_x;
                m_ptr  = (g + 1) % NCH;
            end else if (m_busy) begin
                if (m_k >= 4 && out_ready) m_busy = 1'b0;
                else m_k++;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
